// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-tick prescaler, H/V counters, pixel-coordinate request port and
// a registered colour/sync output stage that shares one pixel-tick latency.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned COLOR_W  = 4,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HC_W    = $clog2(H_TOTAL),
    localparam int unsigned VC_W    = $clog2(V_TOTAL)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               blank_force,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [HC_W-1:0]    pix_x,
    output logic [VC_W-1:0]    pix_y,
    output logic               pix_req,
    output logic               frame_start,
    output logic               line_start,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]  VC_LAST  = VC_W'(V_TOTAL - 1);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [DIV_W-1:0] r_div;
    logic [HC_W-1:0]  r_hc;
    logic [VC_W-1:0]  r_vc;

    logic        w_ce;
    logic [31:0] w_hc_ext;
    logic [31:0] w_vc_ext;
    logic        w_active;
    logic        w_hsync_on;
    logic        w_vsync_on;
    logic        w_show;

    // Gated by reset so no pulse escapes while reset is held (matters when CLK_DIV == 1).
    assign w_ce = (r_div == DIV_LAST) && !reset;

    assign w_hc_ext   = 32'(r_hc);
    assign w_vc_ext   = 32'(r_vc);
    assign w_active   = (w_hc_ext < H_ACTIVE) && (w_vc_ext < V_ACTIVE);
    assign w_hsync_on = (w_hc_ext >= HS_START) && (w_hc_ext < HS_END);
    assign w_vsync_on = (w_vc_ext >= VS_START) && (w_vc_ext < VS_END);
    assign w_show     = w_active && !blank_force;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div <= '0;
        end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_ce) begin
            if (r_hc == HC_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + VC_W'(1);
            end else begin
                r_hc <= r_hc + HC_W'(1);
            end
        end
    end

    // Output stage samples the same counter value the syncs decode, keeping them aligned.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= !HS_POL;
            VGA_VS <= !VS_POL;
        end else if (w_ce) begin
            VGA_R  <= w_show ? pix_r : '0;
            VGA_G  <= w_show ? pix_g : '0;
            VGA_B  <= w_show ? pix_b : '0;
            VGA_HS <= w_hsync_on ? HS_POL : !HS_POL;
            VGA_VS <= w_vsync_on ? VS_POL : !VS_POL;
        end
    end

    assign pix_x       = r_hc;
    assign pix_y       = r_vc;
    assign pix_req     = w_active;
    assign line_start  = w_ce && (r_hc == '0);
    assign frame_start = w_ce && (r_hc == '0) && (r_vc == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: three geometries checked against a raster model that
// derives every expected output from the elapsed cycle count since reset.
module tb_vga_timing_gen;

    typedef struct {
        int         x;
        int         y;
        bit         req;
        bit         fs;
        bit         ls;
        logic [11:0] rgb;
        bit         hs;
        bit         vs;
    } exp_t;

    // Geometry per DUT: 0 = defaults, 1 = tiny 4/1/1/1 x 2/1/1/1, 2 = odd divider and VS_POL=1.
    int ha  [3] = '{640, 4, 10};
    int hf  [3] = '{16, 1, 2};
    int hsw [3] = '{96, 1, 3};
    int hb  [3] = '{48, 1, 2};
    int va  [3] = '{480, 2, 4};
    int vf  [3] = '{10, 1, 1};
    int vsw [3] = '{2, 1, 2};
    int vb  [3] = '{33, 1, 1};
    int dv  [3] = '{2, 1, 3};
    bit hp  [3] = '{1'b0, 1'b1, 1'b0};
    bit vp  [3] = '{1'b0, 1'b0, 1'b1};

    int         mc     [3];
    bit         m_rst  [3];
    logic [3:0] m_r    [3];
    logic [3:0] m_g    [3];
    logic [3:0] m_b    [3];
    bit         m_hs   [3];
    bit         m_vs   [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned seed     = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic       blk0 = 1'b0, blk1 = 1'b0, blk2 = 1'b0;
    logic [3:0] pr0, pg0, pb0, pr1, pg1, pb1, pr2, pg2, pb2;
    logic [9:0] px0, py0;
    logic [2:0] px1, py1;
    logic [4:0] px2;
    logic [2:0] py2;
    logic       req0, req1, req2, fs0, fs1, fs2, ls0, ls1, ls2;
    logic [3:0] vr0, vg0, vb0, vr1, vg1, vb1, vr2, vg2, vb2;
    logic       hs0, hs1, hs2, vs0, vs1, vs2;

    // Pixel source shared by the bench and the model; DUT 0 red is x[3:0].
    function automatic logic [3:0] pix(input int id, input int ch, input int x, input int y,
                                       input int unsigned s);
        int unsigned h;
        if (id == 0 && ch == 0) return 4'(x);
        h = s ^ 32'(x * (ch * 2 + 3) + y * (id + 7) + ch * 11 + id * 29);
        h = h ^ (h >> 4) ^ (h >> 9);
        return h[3:0];
    endfunction

    assign pr0 = pix(0, 0, int'(px0), int'(py0), seed);
    assign pg0 = pix(0, 1, int'(px0), int'(py0), seed);
    assign pb0 = pix(0, 2, int'(px0), int'(py0), seed);
    assign pr1 = pix(1, 0, int'(px1), int'(py1), seed);
    assign pg1 = pix(1, 1, int'(px1), int'(py1), seed);
    assign pb1 = pix(1, 2, int'(px1), int'(py1), seed);
    assign pr2 = pix(2, 0, int'(px2), int'(py2), seed);
    assign pg2 = pix(2, 1, int'(px2), int'(py2), seed);
    assign pb2 = pix(2, 2, int'(px2), int'(py2), seed);

    vga_timing_gen u_dut0 (
        .CLOCK_50(clk), .reset(rst0), .blank_force(blk0),
        .pix_r(pr0), .pix_g(pg0), .pix_b(pb0),
        .pix_x(px0), .pix_y(py0), .pix_req(req0), .frame_start(fs0), .line_start(ls0),
        .VGA_R(vr0), .VGA_G(vg0), .VGA_B(vb0), .VGA_HS(hs0), .VGA_VS(vs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_W(4)
    ) u_dut1 (
        .CLOCK_50(clk), .reset(rst1), .blank_force(blk1),
        .pix_r(pr1), .pix_g(pg1), .pix_b(pb1),
        .pix_x(px1), .pix_y(py1), .pix_req(req1), .frame_start(fs1), .line_start(ls1),
        .VGA_R(vr1), .VGA_G(vg1), .VGA_B(vb1), .VGA_HS(hs1), .VGA_VS(vs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3), .COLOR_W(4)
    ) u_dut2 (
        .CLOCK_50(clk), .reset(rst2), .blank_force(blk2),
        .pix_r(pr2), .pix_g(pg2), .pix_b(pb2),
        .pix_x(px2), .pix_y(py2), .pix_req(req2), .frame_start(fs2), .line_start(ls2),
        .VGA_R(vr2), .VGA_G(vg2), .VGA_B(vb2), .VGA_HS(hs2), .VGA_VS(vs2)
    );

    function automatic int htot(input int id);
        return ha[id] + hf[id] + hsw[id] + hb[id];
    endfunction

    function automatic int vtot(input int id);
        return va[id] + vf[id] + vsw[id] + vb[id];
    endfunction

    // Advance the model across one clock edge and queue what the DUT must show after it.
    task automatic step(input int id, input bit rst, input bit blk);
        int   pos, x, y;
        bit   ce;
        exp_t e;
        if (rst) begin
            mc[id] = 0;
            m_rst[id] = 1'b1;
            m_r[id] = '0;
            m_g[id] = '0;
            m_b[id] = '0;
            m_hs[id] = !hp[id];
            m_vs[id] = !vp[id];
        end else begin
            if (mc[id] % dv[id] == dv[id] - 1) begin
                pos = mc[id] / dv[id];
                x = pos % htot(id);
                y = (pos / htot(id)) % vtot(id);
                if (x < ha[id] && y < va[id] && !blk) begin
                    m_r[id] = pix(id, 0, x, y, seed);
                    m_g[id] = pix(id, 1, x, y, seed);
                    m_b[id] = pix(id, 2, x, y, seed);
                end else begin
                    m_r[id] = '0;
                    m_g[id] = '0;
                    m_b[id] = '0;
                end
                m_hs[id] = (x >= ha[id] + hf[id] && x < ha[id] + hf[id] + hsw[id]) ?
                           hp[id] : !hp[id];
                m_vs[id] = (y >= va[id] + vf[id] && y < va[id] + vf[id] + vsw[id]) ?
                           vp[id] : !vp[id];
            end
            mc[id]++;
            m_rst[id] = 1'b0;
        end
        pos = mc[id] / dv[id];
        e.x = pos % htot(id);
        e.y = (pos / htot(id)) % vtot(id);
        e.req = (e.x < ha[id]) && (e.y < va[id]);
        ce = !m_rst[id] && (mc[id] % dv[id] == dv[id] - 1);
        e.ls = ce && (e.x == 0);
        e.fs = ce && (e.x == 0) && (e.y == 0);
        e.rgb = {m_r[id], m_g[id], m_b[id]};
        e.hs = m_hs[id];
        e.vs = m_vs[id];
        if (id == 0) q0.push_back(e);
        else if (id == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic cmp(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, id, $time, act, exp);
        end
    endtask

    task automatic check(input int id, input exp_t e, input int ax, input int ay, input bit areq,
                         input bit afs, input bit als, input logic [11:0] argb, input bit ahs,
                         input bit avs);
        cmp("pix_x", id, ax, e.x);
        cmp("pix_y", id, ay, e.y);
        cmp("pix_req", id, int'(areq), int'(e.req));
        cmp("frame_start", id, int'(afs), int'(e.fs));
        cmp("line_start", id, int'(als), int'(e.ls));
        cmp("rgb", id, int'(argb), int'(e.rgb));
        cmp("hsync", id, int'(ahs), int'(e.hs));
        cmp("vsync", id, int'(avs), int'(e.vs));
    endtask

    // Monitor: outputs are present every cycle, so pop one expectation per DUT per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check(0, e, int'(px0), int'(py0), req0, fs0, ls0, {vr0, vg0, vb0}, hs0, vs0);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check(1, e, int'(px1), int'(py1), req1, fs1, ls1, {vr1, vg1, vb1}, hs1, vs1);
        end
        if (q2.size() != 0) begin
            e = q2.pop_front();
            check(2, e, int'(px2), int'(py2), req2, fs2, ls2, {vr2, vg2, vb2}, hs2, vs2);
        end
    end

    initial begin
        bit did_mid;
        int pos0, x0, y0;
        seed = $urandom;
        did_mid = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            pos0 = mc[0] / dv[0];
            x0 = pos0 % htot(0);
            y0 = (pos0 / htot(0)) % vtot(0);
            rst0 = (cyc < 3);
            // Mid-line reset on DUT 0 once the second line reaches hc=300.
            if (!did_mid && !m_rst[0] && x0 == 300 && y0 == 1) begin
                rst0 = 1'b1;
                did_mid = 1'b1;
            end
            rst1 = (cyc < 3) || ($urandom_range(0, 399) == 0);
            rst2 = (cyc < 3) || ($urandom_range(0, 1999) == 0);
            blk0 = (y0 == 2) || (y0 >= 3 && $urandom_range(0, 31) == 0);
            blk1 = ($urandom_range(0, 3) == 0);
            blk2 = ($urandom_range(0, 3) == 0);
            step(0, rst0, blk0);
            step(1, rst1, blk1);
            step(2, rst2, blk2);
        end
        repeat (3) @(negedge clk);
        cmp("drain", -1, q0.size() + q1.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
